game_input_conditioner: RTL and testbench

- Front-end stage directly upstream of the game core.
- Converts raw, bouncy, asynchronous push-buttons into synchronized, debounced, active-low levels, which the core samples.
- Generates the one-cycle frame tick that paces all game motion.
- Resolves illegal left+right input so the core never receives both move requests at once.

---
 rtl/game_input_conditioner_pkg.sv | 12 +
 rtl/game_input_conditioner_debounce.sv | 56 +++++
 rtl/game_input_conditioner.sv | 149 ++++++++++++++
 tb/tb_game_input_conditioner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/game_input_conditioner_pkg.sv
// Purpose : shared default timing constants for the game front end.
// Latency : n/a (constants only).
// Backpressure: n/a; holds no logic.
// Defaults assume a 25 MHz core clock: 60 Hz frame tick, 10 ms debounce,
// half-second long press on start/stop.
package game_input_conditioner_pkg;

    localparam int TICK_DIV_DEF        = 416667;
    localparam int DEBOUNCE_CNT_DEF    = 250000;
    localparam int LONGPRESS_TICKS_DEF = 30;

endpackage

// File: rtl/game_input_conditioner_debounce.sv
// Purpose : 2-flop synchronizer plus persistence-counter debouncer for one raw button.
// Latency : raw edge to o_Stable change = 2 + DEBOUNCE_CNT clocks.
// Backpressure: none; continuously tracks its input.
// Ports: i_Clock, i_Reset (async, active-low), i_Raw (async raw level),
//        o_Stable (accepted level, resets to 1 = released).
module button_debounce #(
    parameter int DEBOUNCE_CNT = 250000
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Raw,
    output logic o_Stable
);

    localparam int              CW       = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any sample that agrees with the accepted level restarts the count, so a
    // new level is taken only after DEBOUNCE_CNT unbroken disagreeing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= i_Raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_Stable = stable_q;

endmodule

// File: rtl/game_input_conditioner.sv
// Purpose : button conditioning (sync + debounce + left/right arbitration) and frame tick for the game core.
// Latency : raw button edge to output = 2 sync + DEBOUNCE_CNT + 1 clocks; tick every TICK_DIV clocks.
// Backpressure: none; outputs are levels/pulses the core samples freely.
// Ports: i_Clock; i_Reset (async, active-low); i_Btn* raw active-low buttons;
//        o_Tick one-clock frame pulse; o_PlayerMoveLeft/Right, o_PlayerBulletShoot,
//        o_GameStartStop debounced active-low levels.
// Build option: GAME_STARTSTOP_LONGPRESS_EN turns o_GameStartStop into a one-clock
//        low pulse after start/stop is held LONGPRESS_TICKS frame ticks.
module game_input_conditioner
    import game_input_conditioner_pkg::*;
#(
    parameter int TICK_DIV        = TICK_DIV_DEF,
    parameter int DEBOUNCE_CNT    = DEBOUNCE_CNT_DEF,
    parameter int LONGPRESS_TICKS = LONGPRESS_TICKS_DEF
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_BtnLeft,
    input  logic i_BtnRight,
    input  logic i_BtnShoot,
    input  logic i_BtnStartStop,
    output logic o_Tick,
    output logic o_PlayerMoveLeft,
    output logic o_PlayerMoveRight,
    output logic o_PlayerBulletShoot,
    output logic o_GameStartStop
);

    if (TICK_DIV < 2 || DEBOUNCE_CNT < 2 || LONGPRESS_TICKS < 1) begin : g_bad_params
        $error("game_input_conditioner: TICK_DIV/DEBOUNCE_CNT must be >= 2, LONGPRESS_TICKS >= 1");
    end

    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Debounced, accepted levels (active-low).
    logic s_left;
    logic s_right;
    logic s_shoot;
    logic s_ss;

    button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_left (
        .i_Clock (i_Clock), .i_Reset (i_Reset), .i_Raw (i_BtnLeft),      .o_Stable (s_left)
    );
    button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_right (
        .i_Clock (i_Clock), .i_Reset (i_Reset), .i_Raw (i_BtnRight),     .o_Stable (s_right)
    );
    button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_shoot (
        .i_Clock (i_Clock), .i_Reset (i_Reset), .i_Raw (i_BtnShoot),     .o_Stable (s_shoot)
    );
    button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_ss (
        .i_Clock (i_Clock), .i_Reset (i_Reset), .i_Raw (i_BtnStartStop), .o_Stable (s_ss)
    );

    // ---------------- frame tick ----------------
    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;
    logic          tick_q;
    logic          tick_d;

    always_comb begin
        tick_d     = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_d ? '0 : tick_cnt_q + TW'(1);
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
        end
    end

    // ---------------- move arbitration ----------------
    // Left+right together is meaningless to the core, so both read as released.
    logic both_pressed;
    logic left_q;
    logic left_d;
    logic right_q;
    logic right_d;
    logic shoot_q;
    logic shoot_d;
    logic ss_q;
    logic ss_d;

    always_comb begin
        both_pressed = ~s_left & ~s_right;
        left_d       = s_left  | both_pressed;
        right_d      = s_right | both_pressed;
        shoot_d      = s_shoot;
    end

    // ---------------- start/stop ----------------
`ifdef GAME_STARTSTOP_LONGPRESS_EN
    localparam int            LW      = $clog2(LONGPRESS_TICKS + 1);
    localparam logic [LW-1:0] LP_MAX  = LW'(LONGPRESS_TICKS);
    localparam logic [LW-1:0] LP_LAST = LW'(LONGPRESS_TICKS - 1);

    logic [LW-1:0] lp_cnt_q;
    logic [LW-1:0] lp_cnt_d;

    // Count frame ticks while held; saturation at LP_MAX keeps the pulse from
    // repeating until the button is released and pressed again.
    always_comb begin
        lp_cnt_d = lp_cnt_q;
        if (s_ss) begin
            lp_cnt_d = '0;
        end else if (tick_q && (lp_cnt_q != LP_MAX)) begin
            lp_cnt_d = lp_cnt_q + LW'(1);
        end
        ss_d = ~(~s_ss & tick_q & (lp_cnt_q == LP_LAST));
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            lp_cnt_q <= '0;
        end else begin
            lp_cnt_q <= lp_cnt_d;
        end
    end
`else
    always_comb begin
        ss_d = s_ss;
    end
`endif

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            left_q  <= 1'b1;
            right_q <= 1'b1;
            shoot_q <= 1'b1;
            ss_q    <= 1'b1;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            shoot_q <= shoot_d;
            ss_q    <= ss_d;
        end
    end

    assign o_Tick              = tick_q;
    assign o_PlayerMoveLeft    = left_q;
    assign o_PlayerMoveRight   = right_q;
    assign o_PlayerBulletShoot = shoot_q;
    assign o_GameStartStop     = ss_q;

endmodule

// File: tb/tb_game_input_conditioner.sv
// Purpose : directed, table-driven check of game_input_conditioner (TICK_DIV=10, DEBOUNCE_CNT=4, LONGPRESS_TICKS=3).
// Latency : expected button latency 7 clocks from raw edge; tick every 10 clocks after reset release.
// Backpressure: n/a.
module tb_game_input_conditioner;

    localparam int TDIV = 10;

    logic clk;
    logic rst_n;
    logic btn_left, btn_right, btn_shoot, btn_ss;
    logic tick, out_left, out_right, out_shoot, out_ss;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    game_input_conditioner #(
        .TICK_DIV        (TDIV),
        .DEBOUNCE_CNT    (4),
        .LONGPRESS_TICKS (3)
    ) dut (
        .i_Clock             (clk),
        .i_Reset             (rst_n),
        .i_BtnLeft           (btn_left),
        .i_BtnRight          (btn_right),
        .i_BtnShoot          (btn_shoot),
        .i_BtnStartStop      (btn_ss),
        .o_Tick              (tick),
        .o_PlayerMoveLeft    (out_left),
        .o_PlayerMoveRight   (out_right),
        .o_PlayerBulletShoot (out_shoot),
        .o_GameStartStop     (out_ss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks elapsed since reset release; tick expected whenever this is a
    // nonzero multiple of TDIV.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_tick;
            exp_tick = (cyc != 0) && (cyc % TDIV == 0);
            n_vec++;
            if (tick !== exp_tick) begin
                n_err++;
                $display("FAIL tick at cycle %0d: got %b expected %b", cyc, tick, exp_tick);
            end
        end
    end

    // {left, right, shoot, startstop}
    task automatic drive(input logic [3:0] b);
        {btn_left, btn_right, btn_shoot, btn_ss} = b;
    endtask

    task automatic check4(input string what, input int idx, input logic [3:0] exp);
        logic [3:0] act;
        act = {out_left, out_right, out_shoot, out_ss};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d (t=%0t): got LRS/SS=%b expected %b", what, idx, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] btn;     // raw buttons driven for this segment
        int         cycles;  // clocks the segment lasts
        bit         every;   // compare on every clock, not only the last
        logic [3:0] exp;     // expected outputs
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] b, input int n, input bit e, input logic [3:0] x);
        vec_t v;
        v.btn = b; v.cycles = n; v.every = e; v.exp = x;
        return v;
    endfunction

    initial begin
        // idle
        vecs.push_back(mk(4'b1111, 3, 1, 4'b1111));
        // shoot press: unchanged through clock 6, low at clock 7
        vecs.push_back(mk(4'b1101, 6, 1, 4'b1111));
        vecs.push_back(mk(4'b1101, 1, 0, 4'b1101));
        vecs.push_back(mk(4'b1111, 6, 1, 4'b1101));
        vecs.push_back(mk(4'b1111, 1, 0, 4'b1111));
        // 3-clock left glitch: rejected
        vecs.push_back(mk(4'b0111, 3, 1, 4'b1111));
        vecs.push_back(mk(4'b1111, 8, 1, 4'b1111));
        // 4-clock left press: low for clocks 7..10
        vecs.push_back(mk(4'b0111, 4, 1, 4'b1111));
        vecs.push_back(mk(4'b1111, 2, 1, 4'b1111));
        vecs.push_back(mk(4'b1111, 4, 1, 4'b0111));
        vecs.push_back(mk(4'b1111, 1, 0, 4'b1111));
        // left held, then right too: both suppressed
        vecs.push_back(mk(4'b0111, 6, 1, 4'b1111));
        vecs.push_back(mk(4'b0111, 1, 0, 4'b0111));
        vecs.push_back(mk(4'b0011, 6, 1, 4'b0111));
        vecs.push_back(mk(4'b0011, 6, 1, 4'b1111));
        // right released: left back 7 clocks after raw release
        vecs.push_back(mk(4'b0111, 6, 1, 4'b1111));
        vecs.push_back(mk(4'b0111, 1, 0, 4'b0111));
        vecs.push_back(mk(4'b1111, 6, 1, 4'b0111));
        vecs.push_back(mk(4'b1111, 1, 0, 4'b1111));

        rst_n = 1'b0;
        drive(4'b1111);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check4("reset_state", 0, 4'b1111);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].btn);
            for (int k = 1; k <= vecs[i].cycles; k++) begin
                @(negedge clk);
                if (vecs[i].every || k == vecs[i].cycles) check4("vec", i, vecs[i].exp);
            end
        end

        // Reset mid-debounce: left accepted, start/stop still counting.
        drive(4'b0111);
        repeat (4) @(negedge clk);
        drive(4'b0110);
        repeat (3) @(negedge clk);
        check4("pre_reset", 0, 4'b0111);
        #2 rst_n = 1'b0;
        #1 check4("async_reset", 0, 4'b1111);
        n_vec++;
        if (tick !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_tick: got %b expected 0", tick);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            logic [3:0] e;
            @(negedge clk);
            e[3] = (c >= 7) ? 1'b0 : 1'b1;
            e[2] = 1'b1;
            e[1] = 1'b1;
`ifdef GAME_STARTSTOP_LONGPRESS_EN
            e[0] = (c == 31) ? 1'b0 : 1'b1;
`else
            e[0] = (c >= 7) ? 1'b0 : 1'b1;
`endif
            check4("post_reset", c, e);
        end

`ifdef GAME_STARTSTOP_LONGPRESS_EN
        // Short press spanning exactly two ticks: no pulse.
        drive(4'b1111);
        repeat (12) @(negedge clk);
        drive(4'b1110);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            check4("short_press", c, 4'b1111);
        end
        drive(4'b1111);
        for (int c = 21; c <= 45; c++) begin
            @(negedge clk);
            check4("short_press", c, 4'b1111);
        end
`endif

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
